// File: rtl/sine_period_detector.sv
// Period / peak-to-peak / amplitude detector for offset-binary tone samples.
// Uses midscale rising crossings with hysteresis, and reports lock and loss of signal.
module sine_period_detector #(
    parameter int DATA_WIDTH = 12,
    parameter int MIDSCALE   = 2048,
    parameter int HYST       = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_COUNT = 4,
    parameter int PERIOD_TOL = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_sample_valid,
    output logic [CNT_WIDTH-1:0]  o_period,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [DATA_WIDTH-1:0] o_amplitude,
    output logic                  o_meas_valid,
    output logic                  o_locked,
    output logic                  o_timeout
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_NEG  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [DATA_WIDTH-1:0] LVL_HI = DATA_WIDTH'(MIDSCALE + HYST);
    localparam logic [DATA_WIDTH-1:0] LVL_LO = DATA_WIDTH'(MIDSCALE - HYST);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);
    localparam logic [MW-1:0] MATCH_PRE = MW'(LOCK_COUNT - 1);

    logic [1:0]            r_state;
    logic                  r_pos;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_run_max;
    logic [DATA_WIDTH-1:0] r_run_min;
    logic                  r_seeded;
    logic [MW-1:0]         r_match;
    logic [CNT_WIDTH-1:0]  r_period;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] r_min;
    logic [DATA_WIDTH-1:0] r_amp;
    logic                  r_meas_valid;
    logic                  r_locked;
    logic                  r_timeout;

    logic                  w_hi;
    logic                  w_lo;
    logic                  w_rise;
    logic                  w_event;
    logic                  w_tmo;
    logic                  w_match;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [CNT_WIDTH-1:0]  w_diff;
    logic [DATA_WIDTH-1:0] w_span;

    assign w_hi      = (i_sample >= LVL_HI);
    assign w_lo      = (i_sample <= LVL_LO);
    assign w_rise    = ~r_pos & w_hi;
    // INIT advances on the first low sample; NEG and MEASURE advance on rising crossings
    assign w_event   = (r_state == S_INIT) ? w_lo : w_rise;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_tmo     = (w_cnt_inc == CNT_MAX);
    assign w_diff    = (w_cnt_inc >= r_period) ? (w_cnt_inc - r_period) : (r_period - w_cnt_inc);
    assign w_match   = (w_diff <= CNT_WIDTH'(PERIOD_TOL));
    assign w_span    = r_run_max - r_run_min;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_INIT;
            r_pos        <= 1'b0;
            r_cnt        <= '0;
            r_run_max    <= '0;
            r_run_min    <= '0;
            r_seeded     <= 1'b0;
            r_match      <= '0;
            r_period     <= '0;
            r_max        <= '0;
            r_min        <= '0;
            r_amp        <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            if (i_sample_valid) begin
                if (w_hi) begin
                    r_pos <= 1'b1;
                end else if (w_lo) begin
                    r_pos <= 1'b0;
                end
                if (w_event) begin
                    case (r_state)
                        S_INIT: begin
                            r_state <= S_NEG;
                            r_cnt   <= '0;
                        end
                        S_NEG: begin
                            r_state   <= S_MEAS;
                            r_cnt     <= '0;
                            r_run_max <= i_sample;
                            r_run_min <= i_sample;
                            r_seeded  <= 1'b0;
                        end
                        S_MEAS: begin
                            r_period     <= w_cnt_inc;
                            r_max        <= r_run_max;
                            r_min        <= r_run_min;
                            r_amp        <= w_span >> 1;
                            r_meas_valid <= 1'b1;
                            r_cnt        <= '0;
                            r_run_max    <= i_sample;
                            r_run_min    <= i_sample;
                            r_seeded     <= 1'b1;
                            // r_period still holds the previous period here
                            if (r_seeded) begin
                                if (w_match) begin
                                    if (r_match != MATCH_MAX) r_match <= r_match + 1'b1;
                                    if (r_match >= MATCH_PRE) r_locked <= 1'b1;
                                end else begin
                                    r_match  <= '0;
                                    r_locked <= 1'b0;
                                end
                            end
                        end
                        default: r_state <= S_INIT;
                    endcase
                end else if (w_tmo) begin
                    r_timeout <= 1'b1;
                    r_state   <= S_INIT;
                    r_cnt     <= '0;
                    r_match   <= '0;
                    r_locked  <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (r_state == S_MEAS) begin
                        if (i_sample > r_run_max) r_run_max <= i_sample;
                        if (i_sample < r_run_min) r_run_min <= i_sample;
                    end
                end
            end
        end
    end

    assign o_period     = r_period;
    assign o_max        = r_max;
    assign o_min        = r_min;
    assign o_amplitude  = r_amp;
    assign o_meas_valid = r_meas_valid;
    assign o_locked     = r_locked;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_sine_period_detector.sv
// Scoreboard bench for sine_period_detector: a behavioural model queues expected
// measurement/timeout events as samples are driven; a monitor pops them as the DUT reports.
module tb_sine_period_detector;

    localparam int HI = 2064;
    localparam int LO = 2032;

    typedef struct {
        bit is_tmo;
        int period;
        int mx;
        int mn;
        int amp;
        bit locked;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] i_sample = '0;
    logic        i_sample_valid = 1'b0;
    logic [15:0] o_period;
    logic [11:0] o_max;
    logic [11:0] o_min;
    logic [11:0] o_amplitude;
    logic        o_meas_valid;
    logic        o_locked;
    logic        o_timeout;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_meas = 0;
    int  n_tmo = 0;
    bit  lock_hist[$];
    ev_t sb[$];

    // behavioural model state
    int m_phase = 0;
    bit m_pos = 0;
    int m_idle = 0;
    int m_wn = 0;
    int m_wmax = 0;
    int m_wmin = 0;
    bit m_seeded = 0;
    int m_streak = 0;
    bit m_lock = 0;
    int m_op = 0;
    int m_omax = 0;
    int m_omin = 0;
    int m_oamp = 0;

    sine_period_detector dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_period       (o_period),
        .o_max          (o_max),
        .o_min          (o_min),
        .o_amplitude    (o_amplitude),
        .o_meas_valid   (o_meas_valid),
        .o_locked       (o_locked),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] sine_val(input int n, input int per, input real amp);
        real x;
        x = 2047.5 + amp * $sin(6.283185307179586 * real'(n) / real'(per));
        return 12'($rtoi(x + 0.5));
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_idle = 0; m_wn = 0; m_wmax = 0; m_wmin = 0;
        m_seeded = 0; m_streak = 0; m_lock = 0;
        m_op = 0; m_omax = 0; m_omin = 0; m_oamp = 0;
    endtask

    task automatic model_timeout();
        ev_t e;
        m_streak = 0;
        m_lock = 0;
        m_phase = 0;
        m_idle = 0;
        e.is_tmo = 1; e.period = m_op; e.mx = m_omax; e.mn = m_omin; e.amp = m_oamp; e.locked = 0;
        sb.push_back(e);
    endtask

    task automatic model_step(input int s);
        bit  rise;
        int  diff;
        ev_t e;
        rise = !m_pos && (s >= HI);
        if (s >= HI) m_pos = 1;
        else if (s <= LO) m_pos = 0;
        if (m_phase == 2) begin
            if (rise) begin
                if (m_seeded) begin
                    diff = (m_wn > m_op) ? m_wn - m_op : m_op - m_wn;
                    if (diff <= 2) begin
                        if (m_streak < 4) m_streak++;
                        if (m_streak == 4) m_lock = 1;
                    end else begin
                        m_streak = 0;
                        m_lock = 0;
                    end
                end
                m_seeded = 1;
                m_op = m_wn; m_omax = m_wmax; m_omin = m_wmin; m_oamp = (m_wmax - m_wmin) / 2;
                e.is_tmo = 0; e.period = m_op; e.mx = m_omax; e.mn = m_omin; e.amp = m_oamp;
                e.locked = m_lock;
                sb.push_back(e);
                m_wn = 1; m_wmax = s; m_wmin = s;
            end else if (m_wn == 65535) begin
                model_timeout();
            end else begin
                m_wn++;
                if (s > m_wmax) m_wmax = s;
                if (s < m_wmin) m_wmin = s;
            end
        end else if (m_phase == 0 && s <= LO) begin
            m_phase = 1;
            m_idle = 0;
        end else if (m_phase == 1 && rise) begin
            m_phase = 2;
            m_wn = 1; m_wmax = s; m_wmin = s;
            m_seeded = 0;
        end else begin
            m_idle++;
            if (m_idle == 65535) model_timeout();
        end
    endtask

    task automatic drive(input bit v, input logic [11:0] s);
        @(posedge clk);
        #1;
        i_sample_valid = v;
        i_sample = s;
        if (v) model_step(int'(s));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 12'($urandom));
    endtask

    task automatic run_sine(input int periods, input int per, input real amp, input bit toggle);
        for (int p = 0; p < periods; p++) begin
            for (int n = 0; n < per; n++) begin
                if (toggle) drive(1'b0, 12'($urandom));
                drive(1'b1, sine_val(n, per, amp));
            end
        end
    endtask

    task automatic new_test();
        n_meas = 0;
        lock_hist.delete();
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_val({pfx, "_period"}, int'(o_period), 0);
        check_val({pfx, "_max"}, int'(o_max), 0);
        check_val({pfx, "_min"}, int'(o_min), 0);
        check_val({pfx, "_amp"}, int'(o_amplitude), 0);
        check_val({pfx, "_meas_valid"}, int'(o_meas_valid), 0);
        check_val({pfx, "_locked"}, int'(o_locked), 0);
        check_val({pfx, "_timeout"}, int'(o_timeout), 0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (o_meas_valid || o_timeout)) begin
            if (o_meas_valid) begin
                n_meas++;
                lock_hist.push_back(o_locked);
            end
            if (o_timeout) n_tmo++;
            if (sb.size() == 0) begin
                check_val("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("ev_meas_valid", int'(o_meas_valid), int'(!e.is_tmo));
                check_val("ev_timeout", int'(o_timeout), int'(e.is_tmo));
                check_val("ev_period", int'(o_period), e.period);
                check_val("ev_max", int'(o_max), e.mx);
                check_val("ev_min", int'(o_min), e.mn);
                check_val("ev_amp", int'(o_amplitude), e.amp);
                check_val("ev_locked", int'(o_locked), int'(e.locked));
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("por");
        @(negedge clk) rst_n = 1'b1;

        // full-scale 360-sample sine, lock on 5th measurement
        new_test();
        run_sine(8, 360, 2047.5, 1'b0);
        idle(2);
        check_val("t1_n_meas", n_meas, 6);
        check_val("t1_lock4", int'(lock_hist[3]), 0);
        check_val("t1_lock5", int'(lock_hist[4]), 1);
        check_val("t1_period", int'(o_period), 360);
        check_val("t1_max", int'(o_max), 4095);
        check_val("t1_min", int'(o_min), 0);
        check_val("t1_amp", int'(o_amplitude), 2047);
        check_val("t1_locked", int'(o_locked), 1);

        // period step 360 -> 400
        new_test();
        run_sine(6, 400, 2047.5, 1'b0);
        idle(2);
        check_val("step_n_meas", n_meas, 6);
        check_val("step_drop", int'(lock_hist[1]), 0);
        check_val("step_still_low", int'(lock_hist[4]), 0);
        check_val("step_relock", int'(lock_hist[5]), 1);
        check_val("step_period", int'(o_period), 400);

        // asynchronous reset mid-period while locked
        for (int n = 0; n < 100; n++) drive(1'b1, sine_val(n, 400, 2047.5));
        idle(1);
        @(posedge clk);
        #3;
        i_sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // half-amplitude sine after reset needs NEG -> crossing -> crossing
        new_test();
        run_sine(4, 360, 1023.5, 1'b0);
        idle(2);
        check_val("half_n_meas", n_meas, 2);
        check_val("half_amp", int'(o_amplitude), 1023);
        check_val("half_max", int'(o_max), 3071);
        check_val("half_min", int'(o_min), 1024);
        check_val("half_locked", int'(o_locked), 0);

        // 90-sample sine with valid every other cycle
        new_test();
        run_sine(8, 90, 2047.5, 1'b1);
        idle(2);
        check_val("t2_n_meas", n_meas, 8);
        check_val("t2_lock5", int'(lock_hist[4]), 0);
        check_val("t2_lock6", int'(lock_hist[5]), 1);
        check_val("t2_period", int'(o_period), 90);

        // in-band noise then flat midscale until loss of signal
        new_test();
        n_tmo = 0;
        for (int k = 0; k < 200; k++) drive(1'b1, 12'(2038 + $urandom_range(0, 20)));
        for (int k = 0; k < 66000 && n_tmo == 0; k++) drive(1'b1, 12'd2048);
        idle(2);
        check_val("tmo_count", n_tmo, 1);
        check_val("tmo_no_meas", n_meas, 0);
        check_val("tmo_locked", int'(o_locked), 0);
        check_val("tmo_period_held", int'(o_period), 90);

        // back in INIT: 3 periods yield exactly one measurement
        new_test();
        run_sine(3, 360, 2047.5, 1'b0);
        idle(2);
        check_val("reinit_n_meas", n_meas, 1);
        check_val("reinit_period", int'(o_period), 360);
        check_val("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sine_period_detector.md
Name: sine_period_detector

Overview:
- Receive end of the tone-generation path: consumes a 12-bit offset-binary sample stream from the sine LUT generator or from the ADC capture path.
- Measures the waveform period in samples, its peak-to-peak extent and its amplitude, using midscale crossings with hysteresis.
- Reports lock once the period is stable and flags loss of signal.
- Used for self-check of the carrier and modulating tones, and as the front end of the AM envelope and demodulation chain.

Parameters:
- DATA_WIDTH, 12: sample width, unsigned offset-binary.
- MIDSCALE, 2048: zero-level code.
- HYST, 16: hysteresis half-band in codes around MIDSCALE.
- CNT_WIDTH, 16: period counter width.
- LOCK_COUNT, 4: consecutive matching periods required for lock.
- PERIOD_TOL, 2: allowed |period − previous period| for a match.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sample  in  DATA_WIDTH  input sample.
- i_sample_valid  in  1  i_sample is valid this cycle; all counting is per valid sample.
- o_period  out  CNT_WIDTH  last measured period in samples.
- o_max  out  DATA_WIDTH  maximum sample over the last period.
- o_min  out  DATA_WIDTH  minimum sample over the last period.
- o_amplitude  out  DATA_WIDTH  (o_max − o_min) >> 1.
- o_meas_valid  out  1  one-cycle pulse when a new measurement is registered.
- o_locked  out  1  period stable.
- o_timeout  out  1  one-cycle pulse on loss of signal.

Behaviour:
- Reset (asynchronous assert): all outputs 0, state INIT, counters and match count 0. Reset release is synchronous to i_clk.
- Invalid cycles (i_sample_valid = 0): state, counters and outputs hold. o_meas_valid and o_timeout are 0.
- Polarity tracker:
  - Sample >= MIDSCALE+HYST sets pos = 1.
  - Sample <= MIDSCALE−HYST sets pos = 0.
  - Samples inside the band keep pos.
  - A rising crossing is a pos 0→1 transition on a valid sample.
- State machine:
  - INIT → NEG on the first sample <= MIDSCALE−HYST. Samples above the band in INIT set pos = 1 and produce no crossing.
  - NEG → MEASURE on the first rising crossing. At that crossing: cnt = 0, run_max = run_min = sample. No output.
  - MEASURE, non-crossing valid sample: cnt++, run_max = max(run_max, sample), run_min = min(run_min, sample).
  - MEASURE, rising crossing: registers o_period = cnt+1, o_max = run_max, o_min = run_min, o_amplitude = (run_max − run_min) >> 1. Pulses o_meas_valid. Restarts cnt = 0 and run_max = run_min = sample.
  - Latency: outputs and o_meas_valid appear on the clock edge that samples the crossing sample, i.e. one cycle after it is presented.
- Lock:
  - On each measurement after the first in MEASURE, compare with the previous period.
  - |diff| <= PERIOD_TOL: match_cnt++, saturating at LOCK_COUNT.
  - Otherwise: match_cnt = 0 and o_locked = 0.
  - o_locked = 1 when match_cnt reaches LOCK_COUNT; it asserts in the same cycle as that o_meas_valid.
  - The first measurement after entering MEASURE only seeds the comparison.
- Timeout:
  - cnt reaching 2^CNT_WIDTH−1 in MEASURE pulses o_timeout for one cycle and goes to INIT.
  - It also clears o_locked and match_cnt. o_period, o_max, o_min and o_amplitude hold their last values.
  - The same timeout applies in NEG and INIT, using the same counter incremented on valid samples.
- Arithmetic: the subtraction is unsigned and never negative because run_max >= run_min. The shift truncates.
- Reset mid-measurement: all partial state is discarded and measurement restarts from INIT.

Test Plan:
- Ideal full-scale sine, 360 samples/period, every cycle valid → first o_meas_valid after 2nd rising crossing with o_period = 360, o_max = 4095, o_min = 0, o_amplitude = 2047. o_locked = 1 on the 5th measurement.
- Same sine at 90 samples/period with i_sample_valid toggling every other cycle → o_period = 90 (counts valid samples only), lock after 5 measurements.
- Half-amplitude sine, peaks 3071/1024, 360 samples → o_amplitude = 1023.
- Period step 360 → 400 after lock → o_locked drops on the first 400 measurement, re-asserts 4 matching periods later with o_period = 400.
- ±10-code noise around midscale only, then constant 2048 → no o_meas_valid. After 65535 valid samples o_timeout pulses once and state returns to INIT.
- Assert i_rst_n low mid-period while locked → all outputs 0 immediately without a clock edge. After release, the first new measurement needs a fresh NEG → crossing → crossing sequence.
